histogram_cdf_olusturucu: RTL and testbench
===========================================

# histogram_cdf_olusturucu

Builds the 256-bin grey-level histogram of one M×N 8-bit frame, converts it to a cumulative distribution (CDF), and serves per-pixel CDF lookups together with cdf_min. It sits directly upstream of `histogram_esitleme`: `cdf_o`, `cdf_min_o` and `etkin_o` connect to that block's `cdf_i`, `cdf_min_i` and `etkin_i`, and both blocks share `stal_i`.

## Interface
- `M`, default 320: frame width in pixels.
- `N`, default 240: frame height in pixels. M*N must be ≤ 131071 so that every count fits in 17 bits.

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `piksel_i` in 8: pixel value for the histogram.
- `piksel_gecerli_i` in 1: `piksel_i` is valid. Accepted only in state TOPLA.
- `mesgul_o` out 1: high in every state except TOPLA. Pixels offered while it is high are dropped.
- `cdf_hazir_o` out 1: high while in SORGU, meaning the CDF table is valid.
- `sorgu_i` in 8: grey level to look up.
- `sorgu_gecerli_i` in 1: `sorgu_i` is valid. Honoured only in SORGU with `stal_i` low.
- `stal_i` in 1: pipeline stall shared with the downstream stage.
- `kare_bitti_i` in 1: single-cycle pulse that releases the table. SORGU → TOPLA.
- `cdf_o` out 17: CDF value for the looked-up grey level.
- `cdf_min_o` out 17: CDF of the lowest non-empty bin.
- `etkin_o` out 1: `cdf_o` and `cdf_min_o` are valid this cycle.

## Operation
- Storage:
  - `hist[256]` × 17 bits and `cdf[256]` × 17 bits, both flop arrays with combinational read.
  - Pixel counter, 17 bits.
  - Scan index, 8 bits.
  - Running accumulator, 17 bits.
  - Flag `min_bulundu`.
- States:
  - SIFIRLA: entered on reset. Writes `hist[idx]=0` for idx 0..255 over 256 cycles, then → TOPLA.
  - TOPLA: each accepted pixel is registered (`p_r`, `p_v`). The following cycle writes `hist[p_r]+1`. Because reads are combinational, there is no read-modify-write hazard. When the accepted-pixel count reaches M*N → BOSALT and the counter clears.
  - BOSALT: one cycle that retires the final pending increment. → TARA with idx=0 and accumulator=0.
  - TARA: one bin per cycle.
    - `acc_n = acc + hist[idx]`; write `cdf[idx]=acc_n` and `hist[idx]=0`.
    - If `min_bulundu` is clear and `hist[idx]≠0`, latch `cdf_min_o=acc_n` and set `min_bulundu`.
    - At idx=255 → SORGU.
  - SORGU: `cdf_hazir_o=1`. `kare_bitti_i` → TOPLA and clears `min_bulundu`. Because TARA has already zeroed the histogram, no SIFIRLA pass is needed between frames.
- Lookup path, active only in SORGU:
  - With `stal_i=0` and `sorgu_gecerli_i=1`, register `cdf_o=cdf[sorgu_i]` and `etkin_o=1`.
  - With `stal_i=0` and no query, `etkin_o=0`.
  - With `stal_i=1`, `cdf_o` and `etkin_o` hold, and the query is ignored. The source must hold it.
- `kare_bitti_i` outside SORGU is ignored. `kare_bitti_i` arriving together with a query: the query is served and `etkin_o` pulses, and the state still changes.
- `stal_i` has no effect on SIFIRLA, TOPLA, BOSALT or TARA.
- All arithmetic is unsigned 17-bit. A bin cannot exceed M*N, so nothing saturates.

## Timing
- Reset values: `mesgul_o=1`, `cdf_hazir_o=0`, `cdf_o=0`, `cdf_min_o=0`, `etkin_o=0`. State is SIFIRLA and all counters are 0.
- After `rst_i` deasserts, `mesgul_o` falls after 256 edges.
- `cdf_hazir_o` rises 257 edges after the edge that accepts the M*N-th pixel: 1 edge in BOSALT plus 256 in TARA.
- Lookup latency is 1 cycle: a query at edge t gives `etkin_o`/`cdf_o` valid after edge t.
- `cdf_min_o` is stable throughout SORGU and holds until the next TARA latch.
- Asserting `rst_i` in any state, including mid-TARA, immediately forces the reset values and restarts SIFIRLA. Partial histogram and CDF contents are discarded.

## Configuration
- `HIST_TASMA_EN`:
  - Defined: adds an output port `tasma_o` (1 bit).
    - It is a sticky flag, set when `piksel_gecerli_i=1` arrives while `mesgul_o=1` outside SIFIRLA, i.e. a pixel is dropped.
    - It clears only on `rst_i`. Its reset value is 0.
  - Undefined: the port is absent and dropped pixels are silently discarded.

## Test plan
- M=4, N=2. After SIFIRLA, send pixels 5,5,5,7,7,200,255,5 on consecutive cycles. Then 257 edges later `cdf_hazir_o=1`, and:
  - Lookups 4,5,6,7,199,200,255 → `cdf_o` 0,4,4,6,6,7,8.
  - `cdf_min_o=4`.
  - Each `etkin_o` appears 1 cycle after its query.
- M=4, N=2, all eight pixels = 9 → `cdf_o` 0 for lookup 8, 8 for lookups 9 and 255. `cdf_min_o=8`.
- Stall:
  - Query 7 in SORGU, then hold `stal_i=1` for 3 cycles with `sorgu_i=200` → `cdf_o` stays 6 and `etkin_o` stays 1.
  - After release → `cdf_o=7` next cycle.
- Pulse `kare_bitti_i`, then send a second frame of eight 0s → `cdf[0]=8`, `cdf_min_o=8`, and no stale bins from frame one: lookup 5 → 8.
- Assert `rst_i` at TARA idx 100 → all outputs take their reset values immediately, `mesgul_o=1` for 256 cycles, and the next frame produces correct values.
- `HIST_TASMA_EN` defined: send a pixel during TARA → `tasma_o=1` persists until `rst_i`. The same pixel sent with the macro undefined leaves `cdf` unaffected.

Source files
------------

// File: rtl/histogram_cdf_olusturucu.sv
// rtl/histogram_cdf_olusturucu.sv - frame grey-level histogram to CDF table with per-pixel lookup
// Optional HIST_TASMA_EN adds a sticky tasma_o flag for dropped pixels.
module histogram_cdf_olusturucu #(
  parameter int M = 320,
  parameter int N = 240
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  piksel_i,
  input  logic        piksel_gecerli_i,
  output logic        mesgul_o,
  output logic        cdf_hazir_o,
  input  logic [7:0]  sorgu_i,
  input  logic        sorgu_gecerli_i,
  input  logic        stal_i,
  input  logic        kare_bitti_i,
  output logic [16:0] cdf_o,
  output logic [16:0] cdf_min_o,
`ifdef HIST_TASMA_EN
  output logic        tasma_o,
`endif
  output logic        etkin_o
);

  localparam logic [2:0] SIFIRLA = 3'd0;
  localparam logic [2:0] TOPLA   = 3'd1;
  localparam logic [2:0] BOSALT  = 3'd2;
  localparam logic [2:0] TARA    = 3'd3;
  localparam logic [2:0] SORGU   = 3'd4;

  localparam logic [16:0] TOPLAM = 17'(M * N);

  logic [2:0]  durum;
  logic [16:0] hist [256];
  logic [16:0] cdf  [256];
  logic [16:0] sayac;
  logic [7:0]  idx;
  logic [16:0] acc;
  logic [16:0] acc_n;
  logic        min_bulundu;
  logic [7:0]  p_r;
  logic        p_v;
  logic        kabul;

  assign mesgul_o    = (durum != TOPLA);
  assign cdf_hazir_o = (durum == SORGU);
  assign kabul       = (durum == TOPLA) && piksel_gecerli_i;
  assign acc_n       = acc + hist[idx];

  // Table storage: reset state SIFIRLA clears hist, TARA overwrites every cdf entry.
  always_ff @(posedge clk_i) begin
    case (durum)
      SIFIRLA: hist[idx] <= '0;
      TOPLA, BOSALT: begin
        if (p_v) hist[p_r] <= hist[p_r] + 17'd1;
      end
      TARA: begin
        hist[idx] <= '0;
        cdf[idx]  <= acc_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum       <= SIFIRLA;
      sayac       <= '0;
      idx         <= '0;
      acc         <= '0;
      min_bulundu <= 1'b0;
      p_r         <= '0;
      p_v         <= 1'b0;
      cdf_min_o   <= '0;
    end else begin
      p_v <= kabul;
      if (kabul) p_r <= piksel_i;
      case (durum)
        SIFIRLA: begin
          idx <= idx + 8'd1;
          if (idx == 8'd255) durum <= TOPLA;
        end
        TOPLA: begin
          if (kabul) begin
            if (sayac + 17'd1 == TOPLAM) begin
              sayac <= '0;
              durum <= BOSALT;
            end else begin
              sayac <= sayac + 17'd1;
            end
          end
        end
        BOSALT: begin
          idx   <= '0;
          acc   <= '0;
          durum <= TARA;
        end
        TARA: begin
          acc <= acc_n;
          idx <= idx + 8'd1;
          if (!min_bulundu && hist[idx] != 17'd0) begin
            cdf_min_o   <= acc_n;
            min_bulundu <= 1'b1;
          end
          if (idx == 8'd255) durum <= SORGU;
        end
        SORGU: begin
          if (kare_bitti_i) begin
            durum       <= TOPLA;
            min_bulundu <= 1'b0;
          end
        end
        default: durum <= SIFIRLA;
      endcase
    end
  end

  // Lookup stage: a stall freezes the registered result for the downstream block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdf_o   <= '0;
      etkin_o <= 1'b0;
    end else if (durum != SORGU) begin
      etkin_o <= 1'b0;
    end else if (!stal_i) begin
      etkin_o <= sorgu_gecerli_i;
      if (sorgu_gecerli_i) cdf_o <= cdf[sorgu_i];
    end
  end

`ifdef HIST_TASMA_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tasma_o <= 1'b0;
    else if (piksel_gecerli_i && mesgul_o && durum != SIFIRLA) tasma_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_histogram_cdf_olusturucu.sv
// tb/tb_histogram_cdf_olusturucu.sv - scoreboard bench for histogram_cdf_olusturucu (M=4, N=2)
module tb_histogram_cdf_olusturucu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  piksel_i = '0;
  logic        piksel_gecerli_i = 1'b0;
  logic        mesgul_o;
  logic        cdf_hazir_o;
  logic [7:0]  sorgu_i = '0;
  logic        sorgu_gecerli_i = 1'b0;
  logic        stal_i = 1'b0;
  logic        kare_bitti_i = 1'b0;
  logic [16:0] cdf_o;
  logic [16:0] cdf_min_o;
  logic        etkin_o;
`ifdef HIST_TASMA_EN
  logic        tasma_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [16:0] sb [$];
  logic        stal_s;

  histogram_cdf_olusturucu #(.M(4), .N(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .piksel_i(piksel_i), .piksel_gecerli_i(piksel_gecerli_i),
    .mesgul_o(mesgul_o), .cdf_hazir_o(cdf_hazir_o), .sorgu_i(sorgu_i),
    .sorgu_gecerli_i(sorgu_gecerli_i), .stal_i(stal_i), .kare_bitti_i(kare_bitti_i),
    .cdf_o(cdf_o), .cdf_min_o(cdf_min_o),
`ifdef HIST_TASMA_EN
    .tasma_o(tasma_o),
`endif
    .etkin_o(etkin_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a fresh result exists after every unstalled edge with etkin_o high.
  always begin
    @(posedge clk_i);
    stal_s = stal_i;
    #1;
    if (etkin_o && !stal_s && !rst_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got cdf %0d with no expected entry", cdf_o);
      end else begin
        chk("sb_cdf", 32'(cdf_o), 32'(sb.pop_front()));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mesgul"}, 32'(mesgul_o), 32'd1);
    chk({tag, "_hazir"}, 32'(cdf_hazir_o), 32'd0);
    chk({tag, "_cdf"}, 32'(cdf_o), 32'd0);
    chk({tag, "_cdf_min"}, 32'(cdf_min_o), 32'd0);
    chk({tag, "_etkin"}, 32'(etkin_o), 32'd0);
  endtask

  task automatic release_reset;
    int n;
    @(negedge clk_i);
    rst_i = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk_i); #1;
      n++;
      if (!mesgul_o) break;
    end
    chk("sifirla_edges", 32'(n), 32'd256);
  endtask

  task automatic send_pixels(input logic [63:0] pix);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      piksel_i = pix[8*i +: 8];
      piksel_gecerli_i = 1'b1;
    end
    @(posedge clk_i); #1;
    piksel_gecerli_i = 1'b0;
  endtask

  task automatic wait_ready(input int drop_at);
    int n;
    n = 0;
    while (n < 400) begin
      @(posedge clk_i); #1;
      piksel_gecerli_i = 1'b0;
      n++;
      if (cdf_hazir_o) break;
      if (n == drop_at) begin
        piksel_i = 8'd6;
        piksel_gecerli_i = 1'b1;
      end
    end
    chk("hazir_edges", 32'(n), 32'd257);
  endtask

  task automatic query(input logic [7:0] v, input logic [16:0] e);
    @(negedge clk_i);
    sorgu_i = v;
    sorgu_gecerli_i = 1'b1;
    sb.push_back(e);
  endtask

  task automatic query_end;
    @(negedge clk_i);
    sorgu_gecerli_i = 1'b0;
    @(posedge clk_i); #1;
    chk("etkin_idle", 32'(etkin_o), 32'd0);
  endtask

  task automatic next_frame;
    @(negedge clk_i);
    kare_bitti_i = 1'b1;
    @(negedge clk_i);
    kare_bitti_i = 1'b0;
    chk("mesgul_after_kb", 32'(mesgul_o), 32'd0);
  endtask

  localparam logic [63:0] FRAME1 = {8'd5, 8'd255, 8'd200, 8'd7, 8'd7, 8'd5, 8'd5, 8'd5};

  initial begin
    #2;
    check_reset_vals("rst0");
    release_reset();

    // Frame one: mixed bins
    send_pixels(FRAME1);
    wait_ready(0);
    chk("f1_cdf_min", 32'(cdf_min_o), 32'd4);
    query(8'd4, 17'd0);
    query(8'd5, 17'd4);
    query(8'd6, 17'd4);
    query(8'd7, 17'd6);
    query(8'd199, 17'd6);
    query(8'd200, 17'd7);
    query(8'd255, 17'd8);
    query_end();

    // Stall holds the previous result
    query(8'd7, 17'd6);
    @(negedge clk_i);
    stal_i = 1'b1;
    sorgu_i = 8'd200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("stall_cdf", 32'(cdf_o), 32'd6);
      chk("stall_etkin", 32'(etkin_o), 32'd1);
      if (i < 2) @(negedge clk_i);
    end
    @(negedge clk_i);
    stal_i = 1'b0;
    sb.push_back(17'd7);
    query_end();
    chk("stall_cdf_after", 32'(cdf_o), 32'd7);

    // Second frame of zeros, no stale bins
    next_frame();
    send_pixels(64'd0);
    wait_ready(0);
    chk("f2_cdf_min", 32'(cdf_min_o), 32'd8);
    query(8'd0, 17'd8);
    query(8'd5, 17'd8);
    query(8'd255, 17'd8);
    // Query together with kare_bitti: served and state still changes
    @(negedge clk_i);
    sorgu_i = 8'd0;
    sorgu_gecerli_i = 1'b1;
    kare_bitti_i = 1'b1;
    sb.push_back(17'd8);
    @(negedge clk_i);
    sorgu_gecerli_i = 1'b0;
    kare_bitti_i = 1'b0;
    chk("mesgul_after_kb_q", 32'(mesgul_o), 32'd0);

    // Third frame: all nines
    send_pixels({8{8'd9}});
    wait_ready(0);
    chk("f3_cdf_min", 32'(cdf_min_o), 32'd8);
    query(8'd8, 17'd0);
    query(8'd9, 17'd8);
    query(8'd255, 17'd8);
    query_end();

    // Reset at TARA idx 100
    next_frame();
    send_pixels(FRAME1);
    repeat (101) @(posedge clk_i);
    #1;
    chk("pre_rst_hazir", 32'(cdf_hazir_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check_reset_vals("rst_tara");
    release_reset();

    // Fresh frame with a dropped pixel during TARA
    send_pixels(FRAME1);
    wait_ready(10);
    chk("f4_cdf_min", 32'(cdf_min_o), 32'd4);
    query(8'd5, 17'd4);
    query(8'd6, 17'd4);
    query(8'd7, 17'd6);
    query(8'd255, 17'd8);
    query_end();
`ifdef HIST_TASMA_EN
    chk("tasma_set", 32'(tasma_o), 32'd1);
    repeat (5) @(posedge clk_i);
    #1;
    chk("tasma_sticky", 32'(tasma_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("tasma_rst", 32'(tasma_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
`endif

    repeat (3) @(posedge clk_i);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
